// File: rtl/id_exe_reg_if.sv
// id_exe_reg_if -- ID->EXE pipeline register bundle.
// Groups the pipeline control strobes, the ID-stage payload (*_in), the
// registered EXE-side copies (*_out), valid_out and bubble_cnt.
//   master : ID/control side (drives *_in, flush, freeze, hazard_in)
//   slave  : the pipeline register (drives *_out, valid_out, bubble_cnt)
interface id_exe_reg_if;
    logic        flush;
    logic        freeze;
    logic        hazard_in;

    logic [8:0]  ctrl_in;
    logic [31:0] Val_Rn_in;
    logic [31:0] Val_Rm_in;
    logic        imm_in;
    logic [11:0] Shift_operand_in;
    logic [23:0] Signed_imm_24_in;
    logic [3:0]  Dest_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic [3:0]  SR_in;
    logic [31:0] PC_in;

    logic [8:0]  ctrl_out;
    logic [31:0] Val_Rn_out;
    logic [31:0] Val_Rm_out;
    logic        imm_out;
    logic [11:0] Shift_operand_out;
    logic [23:0] Signed_imm_24_out;
    logic [3:0]  Dest_out;
    logic [3:0]  src1_out;
    logic [3:0]  src2_out;
    logic [3:0]  SR_out;
    logic [31:0] PC_out;
    logic        valid_out;
    logic [15:0] bubble_cnt;

    modport master (
        output flush, freeze, hazard_in,
        output ctrl_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
        output Signed_imm_24_in, Dest_in, src1_in, src2_in, SR_in, PC_in,
        input  ctrl_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
        input  Signed_imm_24_out, Dest_out, src1_out, src2_out, SR_out, PC_out,
        input  valid_out, bubble_cnt
    );

    modport slave (
        input  flush, freeze, hazard_in,
        input  ctrl_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
        input  Signed_imm_24_in, Dest_in, src1_in, src2_in, SR_in, PC_in,
        output ctrl_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
        output Signed_imm_24_out, Dest_out, src1_out, src2_out, SR_out, PC_out,
        output valid_out, bubble_cnt
    );
endinterface

// File: rtl/id_exe_reg.sv
// id_exe_reg -- ID/EXE pipeline register.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears every output
//   bus  : id_exe_reg_if.slave -- flush/freeze/hazard_in, ID payload in,
//          registered EXE payload out, valid_out, bubble_cnt
// Edge priority: reset > freeze (hold) > flush (load zeros) > normal load.
// Optional macro ID_EXE_PERF_CNT_EN: enables the saturating bubble/squash
// counter; when undefined bubble_cnt is tied to zero.
module id_exe_reg (
    input  logic         clk,
    input  logic         rst,
    id_exe_reg_if.slave  bus
);

    localparam int unsigned PAYLOAD_W = 9 + 32 + 32 + 1 + 12 + 24 + 4 + 4 + 4 + 4 + 32;

    logic [PAYLOAD_W-1:0] payload_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 valid_q;

    // The whole instruction is carried as one vector so load/flush/hold
    // treat every field identically.
    assign payload_d = {bus.ctrl_in, bus.Val_Rn_in, bus.Val_Rm_in, bus.imm_in,
                        bus.Shift_operand_in, bus.Signed_imm_24_in, bus.Dest_in,
                        bus.src1_in, bus.src2_in, bus.SR_in, bus.PC_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else if (bus.freeze) begin
            payload_q <= payload_q;
            valid_q   <= valid_q;
        end else if (bus.flush) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= ~bus.hazard_in;
        end
    end

    assign {bus.ctrl_out, bus.Val_Rn_out, bus.Val_Rm_out, bus.imm_out,
            bus.Shift_operand_out, bus.Signed_imm_24_out, bus.Dest_out,
            bus.src1_out, bus.src2_out, bus.SR_out, bus.PC_out} = payload_q;
    assign bus.valid_out = valid_q;

`ifdef ID_EXE_PERF_CNT_EN
    logic [15:0] cnt_q;

    // Counts every unfrozen edge that inserts a bubble; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!bus.freeze && (bus.flush || bus.hazard_in) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.bubble_cnt = cnt_q;
`else
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg -- self-checking bench for id_exe_reg.
// Keeps an expected-instruction record and a bubble event count, updated per
// clock edge from the pipeline rules, and compares every output against it.
module tb_id_exe_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    id_exe_reg_if bus ();

    id_exe_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  sr;
        logic [31:0] pc;
        logic        valid;
    } instr_t;

    instr_t      exp_q;
    longint      events;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic instr_t zero_instr();
        instr_t z;
        z.ctrl = '0; z.rn = '0; z.rm = '0; z.imm = 1'b0; z.shop = '0; z.simm = '0;
        z.dest = '0; z.s1 = '0; z.s2 = '0; z.sr = '0; z.pc = '0; z.valid = 1'b0;
        return z;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef ID_EXE_PERF_CNT_EN
        return (events > 65535) ? 16'hFFFF : 16'(events);
`else
        return 16'h0000;
`endif
    endfunction

    // Reference behaviour of one rising edge, from the current bus inputs.
    task automatic model_edge();
        if (!bus.freeze) begin
            if (bus.flush) begin
                exp_q = zero_instr();
            end else begin
                exp_q.ctrl  = bus.ctrl_in;          exp_q.rn   = bus.Val_Rn_in;
                exp_q.rm    = bus.Val_Rm_in;        exp_q.imm  = bus.imm_in;
                exp_q.shop  = bus.Shift_operand_in; exp_q.simm = bus.Signed_imm_24_in;
                exp_q.dest  = bus.Dest_in;          exp_q.s1   = bus.src1_in;
                exp_q.s2    = bus.src2_in;          exp_q.sr   = bus.SR_in;
                exp_q.pc    = bus.PC_in;            exp_q.valid = !bus.hazard_in;
            end
            if (bus.flush || bus.hazard_in) events++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctrl"},  64'(bus.ctrl_out),          64'(exp_q.ctrl));
        check({tag, ".rn"},    64'(bus.Val_Rn_out),        64'(exp_q.rn));
        check({tag, ".rm"},    64'(bus.Val_Rm_out),        64'(exp_q.rm));
        check({tag, ".imm"},   64'(bus.imm_out),           64'(exp_q.imm));
        check({tag, ".shop"},  64'(bus.Shift_operand_out), 64'(exp_q.shop));
        check({tag, ".simm"},  64'(bus.Signed_imm_24_out), 64'(exp_q.simm));
        check({tag, ".dest"},  64'(bus.Dest_out),          64'(exp_q.dest));
        check({tag, ".src1"},  64'(bus.src1_out),          64'(exp_q.s1));
        check({tag, ".src2"},  64'(bus.src2_out),          64'(exp_q.s2));
        check({tag, ".sr"},    64'(bus.SR_out),            64'(exp_q.sr));
        check({tag, ".pc"},    64'(bus.PC_out),            64'(exp_q.pc));
        check({tag, ".valid"}, 64'(bus.valid_out),         64'(exp_q.valid));
        check({tag, ".bcnt"},  64'(bus.bubble_cnt),        64'(exp_cnt()));
    endtask

    // One edge: model it, then sample #1 later and compare.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_payload();
        bus.ctrl_in          = 9'($urandom);
        bus.Val_Rn_in        = $urandom;
        bus.Val_Rm_in        = $urandom;
        bus.imm_in           = 1'($urandom);
        bus.Shift_operand_in = 12'($urandom);
        bus.Signed_imm_24_in = 24'($urandom);
        bus.Dest_in          = 4'($urandom);
        bus.src1_in          = 4'($urandom);
        bus.src2_in          = 4'($urandom);
        bus.SR_in            = 4'($urandom);
        bus.PC_in            = $urandom;
    endtask

    task automatic ctl(input logic fr, input logic fl, input logic hz);
        bus.freeze = fr; bus.flush = fl; bus.hazard_in = hz;
    endtask

    task automatic apply_reset_model();
        exp_q  = zero_instr();
        events = 0;
    endtask

    initial begin
        apply_reset_model();
        ctl(1'b0, 1'b0, 1'b0);
        rand_payload();

        // Reset state, held across an edge with live inputs.
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Known-value load.
        bus.ctrl_in = 9'h1A5; bus.Val_Rn_in = 32'h12345678; bus.PC_in = 32'h8;
        tick("load");
        check("load.ctrl_k", 64'(bus.ctrl_out), 64'h1A5);
        check("load.valid_k", 64'(bus.valid_out), 64'h1);

        // Freeze for three edges with changing inputs, then release.
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            ctl(1'b1, 1'($urandom), 1'($urandom));
            tick("freeze");
        end
        check("freeze.pc_k", 64'(bus.PC_out), 64'h8);
        rand_payload();
        ctl(1'b0, 1'b0, 1'b0);
        tick("unfreeze");

        // Flush of a fully-set instruction.
        bus.ctrl_in = 9'h1FF; bus.Dest_in = 4'hA;
        ctl(1'b0, 1'b1, 1'b0);
        tick("flush");
        check("flush.dest_k", 64'(bus.Dest_out), 64'h0);

        // Freeze and flush together are ignored; flush alone then bubbles.
        rand_payload();
        ctl(1'b0, 1'b0, 1'b0);
        tick("preload");
        ctl(1'b1, 1'b1, 1'b0);
        tick("frz_flush");
        ctl(1'b0, 1'b1, 1'b0);
        tick("flush2");
        tick("flush3");

        // Back-to-back normal loads.
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            ctl(1'b0, 1'b0, 1'b0);
            tick("stream");
        end

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            ctl(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
            tick("rand");
        end

        // Asynchronous reset between edges while holding a valid instruction.
        rand_payload();
        ctl(1'b0, 1'b0, 1'b0);
        tick("pre_rst");
        #2;
        rst = 1'b0;
        apply_reset_model();
        #1;
        check_all("async_rst");
        ctl(1'b1, 1'b1, 1'b0);
        tick("rst_hold");
        rst = 1'b1;
        rand_payload();
        ctl(1'b0, 1'b0, 1'b0);
        tick("post_rst");

        // Long hazard run: counter saturates (or stays zero when disabled).
        ctl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all("sat");
`ifdef ID_EXE_PERF_CNT_EN
        check("sat.bcnt_k", 64'(bus.bubble_cnt), 64'hFFFF);
`else
        check("sat.bcnt_k", 64'(bus.bubble_cnt), 64'h0);
`endif
        ctl(1'b0, 1'b1, 1'b0);
        tick("sat_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
